// File: rtl/esm_dwell_sequencer_if.sv
// Request/complete handshake between the dwell sequencer (master) and the
// downstream dwell executor (slave).
interface esm_dwell_sequencer_if #(
    parameter int ENTRY_WIDTH = 8
);
    logic                   dwell_valid;
    logic [ENTRY_WIDTH-1:0] dwell_entry_index;
    logic                   dwell_ready;
    logic                   dwell_done;

    modport master (
        output dwell_valid,
        output dwell_entry_index,
        input  dwell_ready,
        input  dwell_done
    );

    modport slave (
        input  dwell_valid,
        input  dwell_entry_index,
        output dwell_ready,
        output dwell_done
    );
endinterface

// File: rtl/esm_dwell_sequencer.sv
// ESM dwell program sequencer: walks the packed instruction table, applies repeat
// counts and the global dwell counter, and issues one dwell request per step.
module esm_dwell_sequencer #(
    parameter  int NUM_INSTRUCTIONS = 32,
    parameter  int ENTRY_WIDTH      = 8,
    localparam int IW               = $clog2(NUM_INSTRUCTIONS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inst_wr_valid_i,
    input  logic [IW-1:0]                inst_wr_index_i,
    input  logic [31:0]                  inst_wr_data_i,
    input  logic                         program_valid_i,
    input  logic                         program_enable_i,
    input  logic                         program_delayed_start_i,
    input  logic [31:0]                  program_global_counter_init_i,
    input  logic [63:0]                  program_start_time_i,
    input  logic [63:0]                  timestamp_i,
    esm_dwell_sequencer_if.master        dwell_if,
    output logic                         busy_o,
    output logic                         program_done_o,
    output logic [31:0]                  global_counter_o,
    output logic                         inst_wr_dropped_o
);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, FETCH, CHECK, ISSUE, WAIT_DONE, DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [7:0]    rep_q, rep_d;
    logic [31:0]   gc_q, gc_d;
    logic [31:0]   inst_q, inst_d;
    logic [63:0]   start_q, start_d;
    logic          pend_q, pend_d;
    logic          pend_en_q, pend_en_d;
    logic          pend_dly_q, pend_dly_d;
    logic [31:0]   pend_gc_q, pend_gc_d;
    logic [63:0]   pend_start_q, pend_start_d;
    logic          dropped_q, dropped_d;

    logic          apply_new, apply_pend, latch_pend;
    logic          hdr_en, hdr_dly;
    logic [31:0]   hdr_gc;
    logic [63:0]   hdr_start;

    logic [31:0]   inst_mem_q [NUM_INSTRUCTIONS];
    logic          unused_inst_bits;

    // The table has no reset; software loads it while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (inst_wr_valid_i && (state_q == IDLE)) begin
            inst_mem_q[inst_wr_index_i] <= inst_wr_data_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rep_d        = rep_q;
        gc_d         = gc_q;
        inst_d       = inst_q;
        start_d      = start_q;
        pend_d       = pend_q;
        pend_en_d    = pend_en_q;
        pend_dly_d   = pend_dly_q;
        pend_gc_d    = pend_gc_q;
        pend_start_d = pend_start_q;
        dropped_d    = inst_wr_valid_i && (state_q != IDLE);
        apply_new    = 1'b0;
        apply_pend   = 1'b0;
        latch_pend   = 1'b0;
        hdr_en       = program_enable_i;
        hdr_dly      = program_delayed_start_i;
        hdr_gc       = program_global_counter_init_i;
        hdr_start    = program_start_time_i;

        unique case (state_q)
            IDLE: apply_new = program_valid_i;
            WAIT_START: begin
                if (program_valid_i) begin
                    apply_new = 1'b1;
                end else if (timestamp_i >= start_q) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (program_valid_i) begin
                    apply_new = 1'b1;
                end else begin
                    inst_d  = inst_mem_q[pc_q];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (program_valid_i) begin
                    apply_new = 1'b1;
                end else if (!inst_q[0] || (inst_q[1] && (gc_q == 32'd0))) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            // Once the executor has taken the request, a new header must wait for its completion.
            ISSUE: begin
                if (dwell_if.dwell_ready) begin
                    state_d    = WAIT_DONE;
                    latch_pend = program_valid_i;
                end else begin
                    apply_new = program_valid_i;
                end
            end
            WAIT_DONE: begin
                if (dwell_if.dwell_done) begin
                    if (program_valid_i) begin
                        apply_new = 1'b1;
                    end else if (pend_q) begin
                        apply_pend = 1'b1;
                    end else begin
                        if (inst_q[2] && (gc_q != 32'd0)) begin
                            gc_d = gc_q - 32'd1;
                        end
                        if (rep_q < inst_q[15:8]) begin
                            rep_d   = rep_q + 8'd1;
                            state_d = CHECK;
                        end else begin
                            rep_d   = '0;
                            pc_d    = inst_q[24 +: IW];
                            state_d = FETCH;
                        end
                    end
                end else begin
                    latch_pend = program_valid_i;
                end
            end
            DONE: begin
                state_d   = IDLE;
                apply_new = program_valid_i;
            end
            default: state_d = IDLE;
        endcase

        if (latch_pend) begin
            pend_d       = 1'b1;
            pend_en_d    = program_enable_i;
            pend_dly_d   = program_delayed_start_i;
            pend_gc_d    = program_global_counter_init_i;
            pend_start_d = program_start_time_i;
        end

        if (apply_pend) begin
            hdr_en    = pend_en_q;
            hdr_dly   = pend_dly_q;
            hdr_gc    = pend_gc_q;
            hdr_start = pend_start_q;
        end

        // Applying a header discards any in-flight gc update and restarts from slot 0.
        if (apply_new || apply_pend) begin
            gc_d    = hdr_gc;
            pc_d    = '0;
            rep_d   = '0;
            start_d = hdr_start;
            pend_d  = 1'b0;
            state_d = !hdr_en ? IDLE : (hdr_dly ? WAIT_START : FETCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            rep_q        <= '0;
            gc_q         <= '0;
            inst_q       <= '0;
            start_q      <= '0;
            pend_q       <= 1'b0;
            pend_en_q    <= 1'b0;
            pend_dly_q   <= 1'b0;
            pend_gc_q    <= '0;
            pend_start_q <= '0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rep_q        <= rep_d;
            gc_q         <= gc_d;
            inst_q       <= inst_d;
            start_q      <= start_d;
            pend_q       <= pend_d;
            pend_en_q    <= pend_en_d;
            pend_dly_q   <= pend_dly_d;
            pend_gc_q    <= pend_gc_d;
            pend_start_q <= pend_start_d;
            dropped_q    <= dropped_d;
        end
    end

    assign dwell_if.dwell_valid       = (state_q == ISSUE);
    assign dwell_if.dwell_entry_index = ENTRY_WIDTH'(inst_q[23:16]);
    assign busy_o                     = (state_q != IDLE);
    assign program_done_o             = (state_q == DONE);
    assign global_counter_o           = gc_q;
    assign inst_wr_dropped_o          = dropped_q;

    assign unused_inst_bits = ^{inst_q[7:3], inst_q[31:24]};

endmodule

// File: tb/tb_esm_dwell_sequencer.sv
// Directed bench for esm_dwell_sequencer: inputs driven and outputs sampled on the
// falling edge, with a posedge monitor counting accepts and Program_done pulses.
module tb_esm_dwell_sequencer;

    localparam int NUM_INSTRUCTIONS = 32;
    localparam int IW               = 5;
    localparam int ENTRY_WIDTH      = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instWrValid = 1'b0;
    logic [IW-1:0] instWrIndex = '0;
    logic [31:0]   instWrData = '0;
    logic          programValid = 1'b0;
    logic          programEnable = 1'b0;
    logic          programDelayedStart = 1'b0;
    logic [31:0]   programGcInit = '0;
    logic [63:0]   programStartTime = '0;
    logic [63:0]   timestamp = '0;
    logic          busy;
    logic          programDone;
    logic [31:0]   globalCounter;
    logic          instWrDropped;

    int compared = 0;
    int mismatched = 0;
    int doneCount = 0;
    int acceptCount = 0;

    esm_dwell_sequencer_if #(.ENTRY_WIDTH(ENTRY_WIDTH)) dwellIf ();

    esm_dwell_sequencer #(
        .NUM_INSTRUCTIONS(NUM_INSTRUCTIONS),
        .ENTRY_WIDTH     (ENTRY_WIDTH)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .inst_wr_valid_i              (instWrValid),
        .inst_wr_index_i              (instWrIndex),
        .inst_wr_data_i               (instWrData),
        .program_valid_i              (programValid),
        .program_enable_i             (programEnable),
        .program_delayed_start_i      (programDelayedStart),
        .program_global_counter_init_i(programGcInit),
        .program_start_time_i         (programStartTime),
        .timestamp_i                  (timestamp),
        .dwell_if                     (dwellIf),
        .busy_o                       (busy),
        .program_done_o               (programDone),
        .global_counter_o             (globalCounter),
        .inst_wr_dropped_o            (instWrDropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) timestamp <= timestamp + 64'd1;

    always @(posedge clk) begin
        if (programDone) doneCount <= doneCount + 1;
        if (dwellIf.dwell_valid && dwellIf.dwell_ready) acceptCount <= acceptCount + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mkInst(input logic v, input logic chk, input logic dec,
                                           input logic [7:0] rep, input logic [7:0] entry,
                                           input logic [7:0] nxt);
        return {nxt, entry, rep, 5'b0, dec, chk, v};
    endfunction

    task automatic applyStimulus(input logic [IW-1:0] idx, input logic [31:0] data);
        instWrValid = 1'b1;
        instWrIndex = idx;
        instWrData  = data;
        step();
        instWrValid = 1'b0;
    endtask

    task automatic startProgram(input logic en, input logic dly, input logic [31:0] gcInit,
                                input logic [63:0] startTime);
        programEnable       = en;
        programDelayedStart = dly;
        programGcInit       = gcInit;
        programStartTime    = startTime;
        programValid        = 1'b1;
        step();
        programValid        = 1'b0;
    endtask

    task automatic waitIssue(input string tag, input logic [7:0] expEntry, input int maxWait,
                             output int waited);
        waited = 0;
        while (dwellIf.dwell_valid !== 1'b1 && waited < maxWait) begin
            step();
            waited++;
        end
        checkOutput({tag, "_valid"}, 64'(dwellIf.dwell_valid), 64'd1);
        checkOutput({tag, "_entry"}, 64'(dwellIf.dwell_entry_index), 64'(expEntry));
    endtask

    // Expects a request on the bus with dwell_ready high; done pulses 'delay' cycles after accept.
    task automatic finishDwell(input int delay);
        step();
        repeat (delay - 1) step();
        dwellIf.dwell_done = 1'b1;
        step();
        dwellIf.dwell_done = 1'b0;
    endtask

    task automatic waitProgramDone(input string tag, input int maxWait);
        int n;
        n = 0;
        while (programDone !== 1'b1 && n < maxWait) begin
            step();
            n++;
        end
        checkOutput({tag, "_pulse"}, 64'(programDone), 64'd1);
        step();
        checkOutput({tag, "_pulse_end"}, 64'(programDone), 64'd0);
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          w;
        int          n;
        int          extra;
        int          accBefore;
        int          doneBefore;
        logic [63:0] st;
        logic        bad;
        logic        stable;
        logic        accepted;
        logic [7:0]  expSeq [4];

        dwellIf.dwell_ready = 1'b0;
        dwellIf.dwell_done  = 1'b0;

        step();
        step();
        checkOutput("rst_valid", 64'(dwellIf.dwell_valid), 64'd0);
        checkOutput("rst_entry", 64'(dwellIf.dwell_entry_index), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(programDone), 64'd0);
        checkOutput("rst_gc", 64'(globalCounter), 64'd0);
        checkOutput("rst_dropped", 64'(instWrDropped), 64'd0);
        rst_n = 1'b1;
        step();

        $display("[TB] linear program");
        applyStimulus(0, mkInst(1'b1, 1'b0, 1'b0, 8'd0, 8'd5, 8'd1));
        checkOutput("t1_wr_idle", 64'(instWrDropped), 64'd0);
        applyStimulus(1, mkInst(1'b1, 1'b0, 1'b0, 8'd0, 8'd6, 8'd2));
        applyStimulus(2, mkInst(1'b1, 1'b0, 1'b0, 8'd0, 8'd7, 8'd3));
        applyStimulus(3, 32'h0);
        dwellIf.dwell_ready = 1'b1;
        startProgram(1'b1, 1'b0, 32'd0, 64'd0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_novalid", 64'(dwellIf.dwell_valid), 64'd0);
        waitIssue("t1_d0", 8'd5, 20, w);
        checkOutput("t1_lat0", 64'(w), 64'd2);
        finishDwell(10);
        checkOutput("t1_gap", 64'(dwellIf.dwell_valid), 64'd0);
        waitIssue("t1_d1", 8'd6, 20, w);
        checkOutput("t1_lat1", 64'(w), 64'd2);
        finishDwell(10);
        waitIssue("t1_d2", 8'd7, 20, w);
        checkOutput("t1_lat2", 64'(w), 64'd2);
        finishDwell(10);
        step();
        step();
        checkOutput("t1_done_lat", 64'(programDone), 64'd1);
        waitProgramDone("t1_done", 10);

        $display("[TB] repeat and global counter");
        applyStimulus(0, mkInst(1'b1, 1'b1, 1'b1, 8'd4, 8'd9, 8'd0));
        startProgram(1'b1, 1'b0, 32'd7, 64'd0);
        checkOutput("t2_gc_init", 64'(globalCounter), 64'd7);
        for (int k = 0; k < 7; k++) begin
            waitIssue("t2_req", 8'd9, 20, w);
            checkOutput("t2_gc_pre", 64'(globalCounter), 64'(7 - k));
            finishDwell(3);
            checkOutput("t2_gc_post", 64'(globalCounter), 64'(6 - k));
        end
        extra = 0;
        n = 0;
        while (programDone !== 1'b1 && n < 20) begin
            if (dwellIf.dwell_valid === 1'b1) extra++;
            step();
            n++;
        end
        checkOutput("t2_extra_req", 64'(extra), 64'd0);
        waitProgramDone("t2_done", 20);
        checkOutput("t2_gc_final", 64'(globalCounter), 64'd0);

        $display("[TB] delayed start");
        st = timestamp + 64'd1000;
        startProgram(1'b1, 1'b1, 32'd1, st);
        bad = 1'b0;
        n = 0;
        while (timestamp != st && n < 1500) begin
            if (busy !== 1'b1 || dwellIf.dwell_valid !== 1'b0) bad = 1'b1;
            step();
            n++;
        end
        checkOutput("t3_hold", 64'(bad), 64'd0);
        checkOutput("t3_busy_at", 64'(busy), 64'd1);
        checkOutput("t3_novalid_at", 64'(dwellIf.dwell_valid), 64'd0);
        waitIssue("t3_req", 8'd9, 10, w);
        checkOutput("t3_lat", 64'(w), 64'd3);
        finishDwell(2);
        waitProgramDone("t3_done", 10);
        startProgram(1'b1, 1'b1, 32'd1, 64'd0);
        waitIssue("t3b_req", 8'd9, 10, w);
        checkOutput("t3b_lat", 64'(w), 64'd3);
        finishDwell(2);
        waitProgramDone("t3b_done", 10);

        $display("[TB] backpressure");
        applyStimulus(0, mkInst(1'b1, 1'b0, 1'b0, 8'd2, 8'h11, 8'd1));
        applyStimulus(1, mkInst(1'b1, 1'b0, 1'b0, 8'd0, 8'h22, 8'd2));
        applyStimulus(2, 32'h0);
        expSeq[0] = 8'h11;
        expSeq[1] = 8'h11;
        expSeq[2] = 8'h11;
        expSeq[3] = 8'h22;
        dwellIf.dwell_ready = 1'b0;
        accBefore = acceptCount;
        startProgram(1'b1, 1'b0, 32'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            waitIssue("t4_req", expSeq[i], 40, w);
            stable = 1'b1;
            accepted = 1'b0;
            n = 0;
            while (!accepted && n < 200) begin
                if (dwellIf.dwell_valid !== 1'b1 || dwellIf.dwell_entry_index !== expSeq[i]) stable = 1'b0;
                dwellIf.dwell_ready = 1'($urandom_range(0, 1));
                step();
                accepted = dwellIf.dwell_ready;
                n++;
            end
            dwellIf.dwell_ready = 1'b0;
            checkOutput("t4_stable", 64'(stable), 64'd1);
            checkOutput("t4_accepted", 64'(accepted), 64'd1);
            checkOutput("t4_drop", 64'(dwellIf.dwell_valid), 64'd0);
            step();
            dwellIf.dwell_done = 1'b1;
            step();
            dwellIf.dwell_done = 1'b0;
        end
        waitProgramDone("t4_done", 10);
        checkOutput("t4_accepts", 64'(acceptCount - accBefore), 64'd4);

        $display("[TB] supersede during WAIT_DONE");
        applyStimulus(0, mkInst(1'b1, 1'b0, 1'b0, 8'd0, 8'h31, 8'd1));
        applyStimulus(1, mkInst(1'b1, 1'b0, 1'b0, 8'd0, 8'h32, 8'd2));
        applyStimulus(2, 32'h0);
        dwellIf.dwell_ready = 1'b1;
        startProgram(1'b1, 1'b0, 32'h10, 64'd0);
        waitIssue("t5_req0", 8'h31, 10, w);
        doneBefore = doneCount;
        step();
        startProgram(1'b1, 1'b0, 32'h55, 64'd0);
        checkOutput("t5_gc_hold", 64'(globalCounter), 64'h10);
        checkOutput("t5_busy", 64'(busy), 64'd1);
        step();
        dwellIf.dwell_done = 1'b1;
        step();
        dwellIf.dwell_done = 1'b0;
        checkOutput("t5_gc_new", 64'(globalCounter), 64'h55);
        waitIssue("t5_restart", 8'h31, 10, w);
        checkOutput("t5_restart_lat", 64'(w), 64'd2);
        checkOutput("t5_no_done", 64'(doneCount - doneBefore), 64'd0);
        finishDwell(2);
        waitIssue("t5_req1", 8'h32, 10, w);
        finishDwell(2);
        waitProgramDone("t5_done", 10);

        $display("[TB] supersede during ISSUE");
        dwellIf.dwell_ready = 1'b0;
        startProgram(1'b1, 1'b0, 32'h20, 64'd0);
        waitIssue("t5b_req", 8'h31, 10, w);
        accBefore = acceptCount;
        doneBefore = doneCount;
        startProgram(1'b1, 1'b0, 32'h66, 64'd0);
        checkOutput("t5b_drop", 64'(dwellIf.dwell_valid), 64'd0);
        checkOutput("t5b_gc_new", 64'(globalCounter), 64'h66);
        checkOutput("t5b_busy", 64'(busy), 64'd1);
        waitIssue("t5b_restart", 8'h31, 10, w);
        checkOutput("t5b_restart_lat", 64'(w), 64'd2);
        checkOutput("t5b_no_accept", 64'(acceptCount - accBefore), 64'd0);
        checkOutput("t5b_no_done", 64'(doneCount - doneBefore), 64'd0);
        dwellIf.dwell_ready = 1'b1;
        finishDwell(2);
        waitIssue("t5b_req1", 8'h32, 10, w);
        finishDwell(2);
        waitProgramDone("t5b_done", 10);

        $display("[TB] writes while busy");
        startProgram(1'b1, 1'b0, 32'd0, 64'd0);
        waitIssue("t6_req0", 8'h31, 10, w);
        step();
        applyStimulus(0, mkInst(1'b1, 1'b0, 1'b0, 8'd0, 8'hEE, 8'd1));
        checkOutput("t6_dropped", 64'(instWrDropped), 64'd1);
        step();
        checkOutput("t6_dropped_end", 64'(instWrDropped), 64'd0);
        dwellIf.dwell_done = 1'b1;
        step();
        dwellIf.dwell_done = 1'b0;
        waitIssue("t6_req1", 8'h32, 10, w);
        finishDwell(2);
        waitProgramDone("t6_done", 10);
        startProgram(1'b1, 1'b0, 32'd0, 64'd0);
        waitIssue("t6_table", 8'h31, 10, w);
        finishDwell(2);
        waitIssue("t6_table1", 8'h32, 10, w);
        finishDwell(2);
        waitProgramDone("t6_done2", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
